// File: rtl/io_sw_pkg.sv
// io_sw_pkg
// Shared constants and types for the switch-input peripheral.
//   SW_WIDTH            - width of the board switch word
//   DEBOUNCE_CYCLES_DEF - default number of stable cycles before a commit
//   sw_state_e          - debounce FSM states (used when IO_SW_DEBOUNCE_EN is defined)
package io_sw_pkg;

   localparam int SW_WIDTH            = 32;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   typedef enum logic {
      IDLE,
      SETTLE
   } sw_state_e;

endpackage

// File: rtl/io_sw_sync2.sv
// sw_sync2
// Two-flop synchronizer for a multi-bit word that is asynchronous to i_clk.
// Each bit is synchronized independently; word coherency is handled
// downstream by the debouncer, which only commits a word once it is stable.
// Ports:
//   i_clk   - destination clock, rising edge
//   i_reset - asynchronous active-low reset, clears both stages
//   i_d     - asynchronous input word
//   o_q     - synchronized word (second stage)
module sw_sync2 #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] sync1;

   // First stage may go metastable; second stage gives it a full cycle to resolve.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1 <= '0;
         o_q   <= '0;
      end else begin
         sync1 <= i_d;
         o_q   <= sync1;
      end
   end

endmodule

// File: rtl/io_sw_input.sv
// io_sw_input
// Receives the asynchronous board switch word, synchronizes it, debounces it
// as a whole word and presents a stable value to the load/store I/O path.
// A sticky per-bit change mask and a summary flag record every bit that
// changed at a commit since the LSU last acknowledged a read.
//
// Build option: define IO_SW_DEBOUNCE_EN to enable the debounce FSM and
// counter. Without it, every synchronized difference is committed directly
// and DEBOUNCE_CYCLES has no effect.
//
// Ports:
//   i_clk        - system clock, rising edge
//   i_reset      - asynchronous active-low reset
//   i_io_sw      - raw switch word, asynchronous to i_clk
//   i_ack        - one-cycle read acknowledge; clears o_sw_edge / o_sw_changed
//   o_sw_data    - debounced, committed switch word
//   o_sw_edge    - sticky mask of bits that differed at any commit since the last ack
//   o_sw_changed - high while o_sw_edge is non-zero
module io_sw_input
   import io_sw_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [SW_WIDTH-1:0] i_io_sw,
   input  logic                i_ack,
   output logic [SW_WIDTH-1:0] o_sw_data,
   output logic [SW_WIDTH-1:0] o_sw_edge,
   output logic                o_sw_changed
);

   // A counter shorter than two cycles would make the debouncer meaningless.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("io_sw_input: DEBOUNCE_CYCLES must be at least 2");
   end

   logic [SW_WIDTH-1:0] sync2;
   logic                commit;
   logic [SW_WIDTH-1:0] commit_val;

   sw_sync2 #(
      .WIDTH (SW_WIDTH)
   ) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_io_sw),
      .o_q     (sync2)
   );

`ifdef IO_SW_DEBOUNCE_EN
   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   sw_state_e           state, state_nxt;
   logic [SW_WIDTH-1:0] cand, cand_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;

   // Debounce state, candidate word and stability counter.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= IDLE;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cand  <= cand_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A bounce back to the committed word abandons the candidate; any other
   // change restarts the count so a commit needs an unbroken stable run.
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (sync2 != o_sw_data) begin
               cand_nxt  = sync2;
               cnt_nxt   = '0;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (sync2 == o_sw_data) begin
               state_nxt = IDLE;
            end else if (sync2 != cand) begin
               cand_nxt = sync2;
               cnt_nxt  = '0;
            end else if (cnt == CNT_MAX) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign commit_val = cand;
`else
   // No debouncing: any synchronized difference is committed immediately.
   assign commit     = (sync2 != o_sw_data);
   assign commit_val = sync2;
`endif

   // Committed word plus sticky change tracking. When a commit and an ack
   // land on the same edge, the ack clears the old bits and the new
   // differences are kept so no fresh change is lost.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_sw_data    <= '0;
         o_sw_edge    <= '0;
         o_sw_changed <= 1'b0;
      end else if (commit) begin
         o_sw_data    <= commit_val;
         o_sw_edge    <= (i_ack ? '0 : o_sw_edge) | (commit_val ^ o_sw_data);
         o_sw_changed <= 1'b1;
      end else if (i_ack) begin
         o_sw_edge    <= '0;
         o_sw_changed <= 1'b0;
      end
   end

endmodule
